// File: rtl/tthbif_uart_ctrl.sv
// UART command decoder and register file for the TT-HBIF front end (enable, per-lane tap selects).
// Define TTHBIF_UART_CTRL_CSUM_EN to require a third checksum byte (cmd ^ data) on every write.
module tthbif_uart_ctrl #(
    parameter int unsigned          NUM_LANES      = 1,
    parameter int unsigned          TAP_SEL_W      = 2,
    parameter logic [TAP_SEL_W-1:0] RESET_TAP      = '1,
    parameter int unsigned          TIMEOUT_CYCLES = 1048576
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           rx_data_valid_i,
    input  logic [7:0]                     rx_data_i,
    input  logic                           tx_data_ready_i,
    output logic                           tx_data_valid_o,
    output logic [7:0]                     tx_data_o,
    output logic                           en_o,
    output logic [NUM_LANES*TAP_SEL_W-1:0] rx_flop_tap_sel_o,
    output logic [NUM_LANES*TAP_SEL_W-1:0] rx_comb_tap_sel_o,
    output logic [NUM_LANES*TAP_SEL_W-1:0] tx_flop_tap_sel_o,
    output logic [NUM_LANES*TAP_SEL_W-1:0] tx_comb_tap_sel_o
);

    localparam int unsigned TapW   = NUM_LANES * TAP_SEL_W;
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  Ack    = 8'h06;
    localparam logic [7:0]  Nak    = 8'h15;
    localparam logic [7:0]  IdVal  = 8'h48;

    typedef enum logic [1:0] {
        StIdle,
        StWaitData,
        StResp
`ifdef TTHBIF_UART_CTRL_CSUM_EN
        , StWaitCsum
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [6:0]          addr_q, addr_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                en_q, en_d;
    logic                ovf_q, ovf_d;
    logic [TapW-1:0]     rx_flop_q, rx_flop_d, rx_comb_q, rx_comb_d;
    logic [TapW-1:0]     tx_flop_q, tx_flop_d, tx_comb_q, tx_comb_d;
`ifdef TTHBIF_UART_CTRL_CSUM_EN
    logic [7:0]          data_q, data_d;
`endif

    logic       wr_do;
    logic [7:0] wr_data;
    logic       drop;
    logic       writable;
    logic       timed_out;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;

    function automatic logic is_lane(input logic [6:0] a);
        return (a[6:4] == 3'd1) && ({28'd0, a[3:0]} < NUM_LANES);
    endfunction

    assign writable  = (addr_q == 7'h00) || is_lane(addr_q);
    assign timed_out = (timer_q == TimerW'(TIMEOUT_CYCLES - 1));

    // Read data is taken straight from the command byte so it can be latched in the IDLE cycle.
    always_comb begin
        rd_data = 8'h00;
        rd_addr = rx_data_i[6:0];
        if (rd_addr == 7'h00) begin
            rd_data = {ovf_q, 6'b0, en_q};
        end else if (rd_addr == 7'h01) begin
            rd_data = IdVal;
        end else if (rd_addr == 7'h02) begin
            rd_data = 8'(NUM_LANES);
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (rd_addr == 7'(16 + l)) begin
                    rd_data[0 +: TAP_SEL_W] = rx_flop_q[l*TAP_SEL_W +: TAP_SEL_W];
                    rd_data[2 +: TAP_SEL_W] = rx_comb_q[l*TAP_SEL_W +: TAP_SEL_W];
                    rd_data[4 +: TAP_SEL_W] = tx_flop_q[l*TAP_SEL_W +: TAP_SEL_W];
                    rd_data[6 +: TAP_SEL_W] = tx_comb_q[l*TAP_SEL_W +: TAP_SEL_W];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        timer_d   = timer_q;
        tx_data_d = tx_data_q;
        en_d      = en_q;
        ovf_d     = ovf_q;
        rx_flop_d = rx_flop_q;
        rx_comb_d = rx_comb_q;
        tx_flop_d = tx_flop_q;
        tx_comb_d = tx_comb_q;
`ifdef TTHBIF_UART_CTRL_CSUM_EN
        data_d    = data_q;
`endif
        wr_do     = 1'b0;
        wr_data   = 8'h00;
        drop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_data_valid_i) begin
                    addr_d = rx_data_i[6:0];
                    if (rx_data_i[7]) begin
                        state_d = StWaitData;
                        timer_d = '0;
                    end else begin
                        tx_data_d = rd_data;
                        state_d   = StResp;
                    end
                end
            end
            StWaitData: begin
                if (rx_data_valid_i) begin
`ifdef TTHBIF_UART_CTRL_CSUM_EN
                    data_d  = rx_data_i;
                    timer_d = '0;
                    state_d = StWaitCsum;
`else
                    wr_do     = writable;
                    wr_data   = rx_data_i;
                    tx_data_d = writable ? Ack : Nak;
                    state_d   = StResp;
`endif
                end else if (timed_out) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
`ifdef TTHBIF_UART_CTRL_CSUM_EN
            StWaitCsum: begin
                if (rx_data_valid_i) begin
                    wr_do     = writable && (rx_data_i == ({1'b1, addr_q} ^ data_q));
                    wr_data   = data_q;
                    tx_data_d = wr_do ? Ack : Nak;
                    state_d   = StResp;
                end else if (timed_out) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
`endif
            StResp: begin
                // Any byte seen here is lost, including one in the handshake cycle.
                drop = rx_data_valid_i;
                if (tx_data_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr_do) begin
            if (addr_q == 7'h00) begin
                en_d = wr_data[0];
                if (wr_data[7]) begin
                    ovf_d = 1'b0;
                end
            end
            for (int l = 0; l < NUM_LANES; l++) begin
                if (addr_q == 7'(16 + l)) begin
                    rx_flop_d[l*TAP_SEL_W +: TAP_SEL_W] = wr_data[0 +: TAP_SEL_W];
                    rx_comb_d[l*TAP_SEL_W +: TAP_SEL_W] = wr_data[2 +: TAP_SEL_W];
                    tx_flop_d[l*TAP_SEL_W +: TAP_SEL_W] = wr_data[4 +: TAP_SEL_W];
                    tx_comb_d[l*TAP_SEL_W +: TAP_SEL_W] = wr_data[6 +: TAP_SEL_W];
                end
            end
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            timer_q   <= '0;
            tx_data_q <= 8'h00;
            en_q      <= 1'b0;
            ovf_q     <= 1'b0;
            rx_flop_q <= {NUM_LANES{RESET_TAP}};
            rx_comb_q <= {NUM_LANES{RESET_TAP}};
            tx_flop_q <= {NUM_LANES{RESET_TAP}};
            tx_comb_q <= {NUM_LANES{RESET_TAP}};
`ifdef TTHBIF_UART_CTRL_CSUM_EN
            data_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            timer_q   <= timer_d;
            tx_data_q <= tx_data_d;
            en_q      <= en_d;
            ovf_q     <= ovf_d;
            rx_flop_q <= rx_flop_d;
            rx_comb_q <= rx_comb_d;
            tx_flop_q <= tx_flop_d;
            tx_comb_q <= tx_comb_d;
`ifdef TTHBIF_UART_CTRL_CSUM_EN
            data_q    <= data_d;
`endif
        end
    end

    assign tx_data_valid_o   = (state_q == StResp);
    assign tx_data_o         = tx_data_q;
    assign en_o              = en_q;
    assign rx_flop_tap_sel_o = rx_flop_q;
    assign rx_comb_tap_sel_o = rx_comb_q;
    assign tx_flop_tap_sel_o = tx_flop_q;
    assign tx_comb_tap_sel_o = tx_comb_q;

endmodule

// File: tb/tb_tthbif_uart_ctrl.sv
// Directed, table-driven bench for tthbif_uart_ctrl with two lanes and a short timeout.
module tb_tthbif_uart_ctrl;

    localparam int unsigned NL = 2;
    localparam int unsigned W  = 2;
    localparam int unsigned TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rx_v = 1'b0;
    logic [7:0]      rx_d = 8'h00;
    logic            tx_rdy = 1'b0;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            en;
    logic [NL*W-1:0] rx_flop, rx_comb, tx_flop, tx_comb;

    int n_total = 0;
    int n_pass  = 0;

    tthbif_uart_ctrl #(
        .NUM_LANES      (NL),
        .TAP_SEL_W      (W),
        .RESET_TAP      (2'b11),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .rx_data_valid_i   (rx_v),
        .rx_data_i         (rx_d),
        .tx_data_ready_i   (tx_rdy),
        .tx_data_valid_o   (tx_valid),
        .tx_data_o         (tx_data),
        .en_o              (en),
        .rx_flop_tap_sel_o (rx_flop),
        .rx_comb_tap_sel_o (rx_comb),
        .tx_flop_tap_sel_o (tx_flop),
        .tx_comb_tap_sel_o (tx_comb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic       wr;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    endtask

    // All tasks start and end on a negative clock edge.
    task automatic send_byte(input logic [7:0] b);
        rx_v = 1'b1;
        rx_d = b;
        @(negedge clk);
        rx_v = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [7:0] data);
        send_byte(cmd);
        send_byte(data);
`ifdef TTHBIF_UART_CTRL_CSUM_EN
        send_byte(cmd ^ data);
`endif
    endtask

    task automatic get_resp(input string name, input logic [7:0] exp);
        int n = 0;
        while (!tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!tx_valid) begin
            n_total++;
            $display("FAIL %s: no response within 20 cycles, expected 0x%02h", name, exp);
        end else begin
            check(name, tx_data, exp);
            tx_rdy = 1'b1;
            @(negedge clk);
            tx_rdy = 1'b0;
            check({name, "_done"}, 8'(tx_valid), 8'h00);
        end
    endtask

    initial begin
        vecs[0]  = '{8'h01, 8'h00, 1'b0, 8'h48};
        vecs[1]  = '{8'h02, 8'h00, 1'b0, 8'h02};
        vecs[2]  = '{8'h10, 8'h00, 1'b0, 8'hFF};
        vecs[3]  = '{8'h11, 8'h00, 1'b0, 8'hFF};
        vecs[4]  = '{8'h00, 8'h00, 1'b0, 8'h01};
        vecs[5]  = '{8'h91, 8'hE4, 1'b1, 8'h06};
        vecs[6]  = '{8'h11, 8'h00, 1'b0, 8'hE4};
        vecs[7]  = '{8'h81, 8'h55, 1'b1, 8'h15};
        vecs[8]  = '{8'h01, 8'h00, 1'b0, 8'h48};
        vecs[9]  = '{8'hA0, 8'h12, 1'b1, 8'h15};
        vecs[10] = '{8'h20, 8'h00, 1'b0, 8'h00};
        vecs[11] = '{8'h12, 8'h00, 1'b0, 8'h00};
        vecs[12] = '{8'h82, 8'h07, 1'b1, 8'h15};
        vecs[13] = '{8'h10, 8'h00, 1'b0, 8'hFF};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_valid", 8'(tx_valid), 8'h00);
        check("rst_data", tx_data, 8'h00);
        check("rst_en", 8'(en), 8'h00);
        check("rst_rx_flop", 8'(rx_flop), 8'h0F);
        check("rst_rx_comb", 8'(rx_comb), 8'h0F);
        check("rst_tx_flop", 8'(tx_flop), 8'h0F);
        check("rst_tx_comb", 8'(tx_comb), 8'h0F);

        // en follows the cycle after the data byte.
        send_byte(8'h80);
        check("en_before_data", 8'(en), 8'h00);
        send_byte(8'h01);
        check("en_after_data", 8'(en), 8'h01);
        check("ack_latency", 8'(tx_valid), 8'h01);
        get_resp("en_ack", 8'h06);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) do_write(vecs[i].cmd, vecs[i].data);
            else send_byte(vecs[i].cmd);
            check($sformatf("vec%0d_latency", i), 8'(tx_valid), 8'h01);
            get_resp($sformatf("vec%0d", i), vecs[i].exp);
        end

        check("lane1_rx_flop", 8'(rx_flop), 8'h03);
        check("lane1_rx_comb", 8'(rx_comb), 8'h07);
        check("lane1_tx_flop", 8'(tx_flop), 8'h0B);
        check("lane1_tx_comb", 8'(tx_comb), 8'h0F);

        // Overflow: byte during a stalled response is dropped and sets ovf.
        do_write(8'h80, 8'h00);
        get_resp("en_clear", 8'h06);
        send_byte(8'h01);
        send_byte(8'h02);
        check("ovf_hold_valid", 8'(tx_valid), 8'h01);
        check("ovf_hold_data", tx_data, 8'h48);
        @(negedge clk);
        check("ovf_hold_data2", tx_data, 8'h48);
        get_resp("ovf_resp", 8'h48);
        send_byte(8'h00);
        get_resp("ovf_read", 8'h80);
        do_write(8'h80, 8'h80);
        get_resp("ovf_w1c_ack", 8'h06);
        send_byte(8'h00);
        get_resp("ovf_cleared", 8'h00);

        // Byte arriving in the handshake cycle is dropped, not accepted.
        send_byte(8'h01);
        tx_rdy = 1'b1;
        rx_v   = 1'b1;
        rx_d   = 8'h02;
        @(negedge clk);
        tx_rdy = 1'b0;
        rx_v   = 1'b0;
        check("hs_drop_valid", 8'(tx_valid), 8'h00);
        repeat (2) @(negedge clk);
        check("hs_drop_valid2", 8'(tx_valid), 8'h00);
        send_byte(8'h00);
        get_resp("hs_drop_ovf", 8'h80);
        do_write(8'h80, 8'h80);
        get_resp("hs_drop_clr", 8'h06);

        // Timeout: no data byte, no response, back to IDLE.
        send_byte(8'h90);
        for (int c = 0; c < int'(TO) + 2; c++) begin
            if (tx_valid) begin
                n_total++;
                $display("FAIL timeout_no_resp: got valid at cycle %0d, expected 0", c);
            end
            @(negedge clk);
        end
        send_byte(8'h10);
        get_resp("timeout_read", 8'hFF);

        // Data byte in the last permitted cycle is still accepted.
        send_byte(8'h90);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h1B);
        get_resp("timeout_edge_ack", 8'h06);
        send_byte(8'h10);
        get_resp("timeout_edge_read", 8'h1B);

        // Reset aborts a pending response and a half-done write.
        send_byte(8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_resp_valid", 8'(tx_valid), 8'h00);
        check("rst_resp_data", tx_data, 8'h00);
        send_byte(8'h91);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h11);
        get_resp("rst_abort_read", 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
